complex_square_accum: RTL and testbench



---
 rtl/complex_square_accum.sv | 117 +++++++++++
 tb/tb_complex_square_accum.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_square_accum.sv
// Accumulates LEN squared complex samples into a full-precision sum, one result per block,
// with valid/ready on both sides. Define CPLX_ACC_MAG_EN to add the |re|+|im| output outMag.
module complex_square_accum #(
    parameter  int WIDTH = 8,
    parameter  int LEN   = 16,
    localparam int CNT_W = $clog2(LEN),
    localparam int ACC_W = 2*WIDTH + CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WIDTH-1:0]      inReal,
    input  logic [2*WIDTH-1:0]      inImag,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef CPLX_ACC_MAG_EN
    output logic [ACC_W:0]          outMag,
`endif
    output logic [ACC_W-1:0]        outReal,
    output logic [ACC_W-1:0]        outImag
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   accReal_r;
    logic [ACC_W-1:0]   accImag_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   sumReal_s;
    logic [ACC_W-1:0]   sumImag_s;
    logic               lastSample_s;

`ifdef CPLX_ACC_MAG_EN
    // Two's-complement magnitude widened by one bit so the most negative value is representable.
    function automatic logic [ACC_W:0] absExt(input logic [ACC_W-1:0] v);
        logic [ACC_W:0] e;
        e = {v[ACC_W-1], v};
        if (v[ACC_W-1]) begin
            return ~e + (ACC_W+1)'(1);
        end else begin
            return e;
        end
    endfunction
`endif

    // Running sum including the current sample, inputs sign-extended to the accumulator width.
    always_comb begin
        sumReal_s    = accReal_r + {{CNT_W{inReal[2*WIDTH-1]}}, inReal};
        sumImag_s    = accImag_r + {{CNT_W{inImag[2*WIDTH-1]}}, inImag};
        lastSample_s = (cnt_r == CNT_W'(LEN-1));
    end

    // Block sequencer: accumulate in ACCUM, hold the result in DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ACCUM;
            accReal_r <= '0;
            accImag_r <= '0;
            cnt_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outReal   <= '0;
            outImag   <= '0;
`ifdef CPLX_ACC_MAG_EN
            outMag    <= '0;
`endif
        end else begin
            // clr only drops the partial block; a pending result in DONE is left intact.
            if (clr) begin
                accReal_r <= '0;
                accImag_r <= '0;
                cnt_r     <= '0;
            end
            case (state_r)
                ACCUM: begin
                    if (in_valid && !clr) begin
                        if (lastSample_s) begin
                            outReal   <= sumReal_s;
                            outImag   <= sumImag_s;
`ifdef CPLX_ACC_MAG_EN
                            outMag    <= absExt(sumReal_s) + absExt(sumImag_s);
`endif
                            accReal_r <= '0;
                            accImag_r <= '0;
                            cnt_r     <= '0;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state_r   <= DONE;
                        end else begin
                            accReal_r <= sumReal_s;
                            accImag_r <= sumImag_s;
                            cnt_r     <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ACCUM;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_square_accum.sv
// Directed bench for complex_square_accum with WIDTH=8, LEN=4 (ACC_W=18); expected sums are hand-computed.
module tb_complex_square_accum;

    localparam int WIDTH = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 18;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        inReal = '0;
    logic [15:0]        inImag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ACC_W-1:0]   outReal;
    logic [ACC_W-1:0]   outImag;
`ifdef CPLX_ACC_MAG_EN
    logic [ACC_W:0]     outMag;
`endif

    int nChecks = 0;
    int nFails  = 0;

    complex_square_accum #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .inReal(inReal), .inImag(inImag),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef CPLX_ACC_MAG_EN
        .outMag(outMag),
`endif
        .outReal(outReal), .outImag(outImag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int i, input logic c);
        in_valid = 1'b1;
        inReal   = 16'(r);
        inImag   = 16'(i);
        clr      = c;
        tick();
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0 || outReal !== 18'd0 || outImag !== 18'd0 || in_ready !== 1'b1) begin
            nFails++;
            $display("FAIL reset: out_valid=%b outReal=%0d outImag=%0d in_ready=%b, want 0 0 0 1",
                     out_valid, $signed(outReal), $signed(outImag), in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(100, -50, 1'b0);
        send(200, 30, 1'b0);
        send(-20, -20, 1'b0);
        send(5, 5, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== 18'sd285 || outImag !== -18'sd35) begin
            nFails++;
            $display("FAIL basic_result: valid=%b re=%0d im=%0d, want 1 285 -35",
                     out_valid, $signed(outReal), $signed(outImag));
        end
`ifdef CPLX_ACC_MAG_EN
        nChecks++;
        if (outMag !== 19'd320) begin
            nFails++;
            $display("FAIL basic_mag: outMag=%0d, want 320", outMag);
        end
`endif
        tick();
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFails++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_extremes();
        for (int k = 0; k < 4; k++) send(-32768, 32767, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== -18'sd131072 || outImag !== 18'sd131068) begin
            nFails++;
            $display("FAIL extremes: valid=%b re=%0d im=%0d, want 1 -131072 131068",
                     out_valid, $signed(outReal), $signed(outImag));
        end
`ifdef CPLX_ACC_MAG_EN
        nChecks++;
        if (outMag !== 19'd262140) begin
            nFails++;
            $display("FAIL extremes_mag: outMag=%0d, want 262140", outMag);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(10, -10, 1'b0);
        in_valid = 1'b1;
        inReal   = 16'd7;
        inImag   = 16'd7;
        for (int k = 0; k < 5; k++) begin
            nChecks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || outReal !== 18'sd40 || outImag !== -18'sd40) begin
                nFails++;
                $display("FAIL backpressure_hold[%0d]: valid=%b in_ready=%b re=%0d im=%0d, want 1 0 40 -40",
                         k, out_valid, in_ready, $signed(outReal), $signed(outImag));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) send(7, 7, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== 18'sd28 || outImag !== 18'sd28) begin
            nFails++;
            $display("FAIL backpressure_next: valid=%b re=%0d im=%0d, want 1 28 28",
                     out_valid, $signed(outReal), $signed(outImag));
        end
        tick();
    endtask

    task automatic test_clr();
        send(50, 50, 1'b0);
        send(50, 50, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) send(1, 1, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== 18'sd4 || outImag !== 18'sd4) begin
            nFails++;
            $display("FAIL clr_partial: valid=%b re=%0d im=%0d, want 1 4 4",
                     out_valid, $signed(outReal), $signed(outImag));
        end
        tick();
        for (int k = 0; k < 3; k++) send(9, 9, 1'b0);
        send(9, 9, 1'b1);
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFails++;
            $display("FAIL clr_last: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 4; k++) send(2, -2, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== 18'sd8 || outImag !== -18'sd8) begin
            nFails++;
            $display("FAIL clr_after: valid=%b re=%0d im=%0d, want 1 8 -8",
                     out_valid, $signed(outReal), $signed(outImag));
        end
        tick();
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 3; k++) send(5, 5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nFails++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(3, 0, 1'b0);
        nChecks++;
        if (out_valid !== 1'b1 || outReal !== 18'sd12 || outImag !== 18'sd0) begin
            nFails++;
            $display("FAIL rst_mid_next: valid=%b re=%0d im=%0d, want 1 12 0",
                     out_valid, $signed(outReal), $signed(outImag));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || outReal !== 18'd0 || outImag !== 18'd0) begin
            nFails++;
            $display("FAIL rst_done: valid=%b in_ready=%b re=%0d im=%0d, want 0 1 0 0",
                     out_valid, in_ready, $signed(outReal), $signed(outImag));
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_clr();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
